// File: rtl/io_cycle_watchdog.sv
// io_cycle_watchdog: bounds each Host I/O cycle, forcing /READY and logging the fault on expiry
module io_cycle_watchdog #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iorq_n,
    input  logic       r_w_,
    input  logic       win_valid,
    input  logic [3:0] win_index,
    input  logic [2:0] sel_slot,
    input  logic       ready_n,
    input  logic       wd_enable,
    input  logic       irq_ack,
    output logic       host_ready_n,
    output logic       force_ff,
    output logic       fault_valid,
    output logic       fault_overflow,
    output logic [2:0] fault_slot,
    output logic [3:0] fault_win,
    output logic       fault_mapped,
    output logic       fault_read,
    output logic [7:0] fault_count,
    output logic       irq
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXPIRED, S_RELEASE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             ctx_valid;
    logic [3:0]       ctx_win;
    logic [2:0]       ctx_slot;
    logic             ctx_read;
    logic             expire;

    // Expiry fires only when no abort or handshake takes priority in WAIT
    always_comb begin
        expire = (state == S_WAIT) && !iorq_n && ready_n && wd_enable && (counter == LAST);
    end

    // Cycle-tracking state machine with latched cycle context
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            counter   <= '0;
            ctx_valid <= 1'b0;
            ctx_win   <= '0;
            ctx_slot  <= '0;
            ctx_read  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    counter <= '0;
                    if (!iorq_n) begin
                        state     <= S_WAIT;
                        ctx_valid <= win_valid;
                        ctx_win   <= win_index;
                        ctx_slot  <= sel_slot;
                        ctx_read  <= r_w_;
                    end
                end
                S_WAIT: begin
                    if (iorq_n)
                        state <= S_IDLE;
                    else if (!ready_n)
                        state <= S_RELEASE;
                    else if (expire)
                        state <= S_EXPIRED;
                    else
                        counter <= (counter == LAST) ? counter : counter + CNT_W'(1);
                end
                S_EXPIRED: state <= iorq_n ? S_IDLE : S_EXPIRED;
                default:   state <= iorq_n ? S_IDLE : S_RELEASE;
            endcase
        end
    end

    // Fault record: first expiry latched, later ones flag overflow; ack clears, count only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_valid    <= 1'b0;
            fault_overflow <= 1'b0;
            fault_slot     <= '0;
            fault_win      <= '0;
            fault_mapped   <= 1'b0;
            fault_read     <= 1'b0;
            fault_count    <= '0;
        end else begin
            fault_valid    <= expire | (fault_valid & ~irq_ack);
            fault_overflow <= ~irq_ack & (fault_overflow | (expire & fault_valid));
            if (expire) begin
                fault_count <= fault_count + 8'(fault_count != 8'hFF);
                if (!fault_valid || irq_ack) begin
                    fault_slot   <= ctx_slot;
                    fault_win    <= ctx_win;
                    fault_mapped <= ctx_valid;
                    fault_read   <= ctx_read;
                end
            end
        end
    end

    assign host_ready_n = ready_n & (state != S_EXPIRED);
    assign force_ff     = (state == S_EXPIRED) & ctx_read;
    assign irq          = fault_valid;
endmodule

// File: tb/tb_io_cycle_watchdog.sv
// tb_io_cycle_watchdog: directed checks of timeout, fault logging, ack and reset behaviour
module tb_io_cycle_watchdog;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iorq_n = 1'b1;
    logic       r_w_ = 1'b0;
    logic       win_valid = 1'b0;
    logic [3:0] win_index = '0;
    logic [2:0] sel_slot = '0;
    logic       ready_n = 1'b1;
    logic       wd_enable = 1'b1;
    logic       irq_ack = 1'b0;
    logic       host_ready_n;
    logic       force_ff;
    logic       fault_valid;
    logic       fault_overflow;
    logic [2:0] fault_slot;
    logic [3:0] fault_win;
    logic       fault_mapped;
    logic       fault_read;
    logic [7:0] fault_count;
    logic       irq;

    int vectors = 0;
    int miscompares = 0;

    io_cycle_watchdog #(.TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .iorq_n(iorq_n), .r_w_(r_w_), .win_valid(win_valid),
        .win_index(win_index), .sel_slot(sel_slot), .ready_n(ready_n), .wd_enable(wd_enable),
        .irq_ack(irq_ack), .host_ready_n(host_ready_n), .force_ff(force_ff),
        .fault_valid(fault_valid), .fault_overflow(fault_overflow), .fault_slot(fault_slot),
        .fault_win(fault_win), .fault_mapped(fault_mapped), .fault_read(fault_read),
        .fault_count(fault_count), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a cycle and stop just before the edge that would expire it
    task automatic start_stuck(input logic [2:0] slot, input logic [3:0] win, input logic rd, input logic mapped);
        sel_slot  = slot;
        win_index = win;
        r_w_      = rd;
        win_valid = mapped;
        iorq_n    = 1'b0;
        tick();
        tick(15);
    endtask

    task automatic end_cycle();
        iorq_n  = 1'b1;
        ready_n = 1'b1;
        tick();
    endtask

    initial begin
        tick(2);
        rst = 1'b0;
        check("rst_valid", 8'(fault_valid), 8'h0);
        check("rst_count", fault_count, 8'h0);
        check("rst_irq", 8'(irq), 8'h0);
        check("rst_ovf", 8'(fault_overflow), 8'h0);
        check("rst_force", 8'(force_ff), 8'h0);
        check("rst_ready_hi", 8'(host_ready_n), 8'h1);
        ready_n = 1'b0;
        #1;
        check("rst_ready_lo", 8'(host_ready_n), 8'h0);
        ready_n = 1'b1;

        // Normal read completed by the decoder
        sel_slot = 3'd2; win_index = 4'd5; r_w_ = 1'b1; win_valid = 1'b1;
        iorq_n = 1'b0;
        tick();
        tick(5);
        check("ok_ready_wait", 8'(host_ready_n), 8'h1);
        ready_n = 1'b0;
        #1;
        check("ok_ready_follow", 8'(host_ready_n), 8'h0);
        tick();
        check("ok_force", 8'(force_ff), 8'h0);
        end_cycle();
        check("ok_valid", 8'(fault_valid), 8'h0);
        check("ok_count", fault_count, 8'h0);
        check("ok_ready_idle", 8'(host_ready_n), 8'h1);

        // Stuck read: expires exactly 16 cycles after WAIT entry
        start_stuck(3'd3, 4'd7, 1'b1, 1'b1);
        check("pre_exp_ready", 8'(host_ready_n), 8'h1);
        check("pre_exp_force", 8'(force_ff), 8'h0);
        check("pre_exp_valid", 8'(fault_valid), 8'h0);
        tick();
        check("exp_ready", 8'(host_ready_n), 8'h0);
        check("exp_force", 8'(force_ff), 8'h1);
        check("exp_valid", 8'(fault_valid), 8'h1);
        check("exp_irq", 8'(irq), 8'h1);
        check("exp_slot", 8'(fault_slot), 8'h3);
        check("exp_win", 8'(fault_win), 8'h7);
        check("exp_read", 8'(fault_read), 8'h1);
        check("exp_mapped", 8'(fault_mapped), 8'h1);
        check("exp_count", fault_count, 8'h1);
        ready_n = 1'b0;
        tick();
        check("exp_ignore_ready", 8'(host_ready_n), 8'h0);
        end_cycle();
        check("rel_ready", 8'(host_ready_n), 8'h1);
        check("rel_force", 8'(force_ff), 8'h0);

        // Ack, then two stuck writes without ack
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("ack1_valid", 8'(fault_valid), 8'h0);
        check("ack1_count", fault_count, 8'h1);
        start_stuck(3'd4, 4'd9, 1'b0, 1'b0);
        tick();
        check("w1_force", 8'(force_ff), 8'h0);
        check("w1_ready", 8'(host_ready_n), 8'h0);
        check("w1_slot", 8'(fault_slot), 8'h4);
        check("w1_win", 8'(fault_win), 8'h9);
        check("w1_read", 8'(fault_read), 8'h0);
        check("w1_mapped", 8'(fault_mapped), 8'h0);
        check("w1_ovf", 8'(fault_overflow), 8'h0);
        check("w1_count", fault_count, 8'h2);
        end_cycle();
        start_stuck(3'd6, 4'd2, 1'b0, 1'b1);
        tick();
        check("w2_force", 8'(force_ff), 8'h0);
        check("w2_ovf", 8'(fault_overflow), 8'h1);
        check("w2_slot", 8'(fault_slot), 8'h4);
        check("w2_win", 8'(fault_win), 8'h9);
        check("w2_count", fault_count, 8'h3);
        end_cycle();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("ack2_valid", 8'(fault_valid), 8'h0);
        check("ack2_ovf", 8'(fault_overflow), 8'h0);
        check("ack2_count", fault_count, 8'h3);

        // Ack coincident with a new expiry while overflow is set
        start_stuck(3'd5, 4'd3, 1'b1, 1'b1);
        tick();
        end_cycle();
        start_stuck(3'd0, 4'd1, 1'b0, 1'b1);
        tick();
        check("pre_co_ovf", 8'(fault_overflow), 8'h1);
        end_cycle();
        start_stuck(3'd1, 4'd0, 1'b1, 1'b1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("co_valid", 8'(fault_valid), 8'h1);
        check("co_slot", 8'(fault_slot), 8'h1);
        check("co_win", 8'(fault_win), 8'h0);
        check("co_ovf", 8'(fault_overflow), 8'h0);
        check("co_count", fault_count, 8'h6);
        end_cycle();

        // Watchdog disabled: no expiry until enabled, then at the next edge
        wd_enable = 1'b0;
        iorq_n = 1'b0;
        tick();
        tick(100);
        check("dis_ready", 8'(host_ready_n), 8'h1);
        check("dis_count", fault_count, 8'h6);
        wd_enable = 1'b1;
        tick();
        check("en_ready", 8'(host_ready_n), 8'h0);
        check("en_count", fault_count, 8'h7);
        end_cycle();

        // Reset mid-cycle with iorq_n held low
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sel_slot = 3'd2; win_index = 4'd4; r_w_ = 1'b1; win_valid = 1'b1;
        iorq_n = 1'b0;
        tick();
        tick(10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_count", fault_count, 8'h0);
        check("mid_rst_valid", 8'(fault_valid), 8'h0);
        check("mid_rst_ready", 8'(host_ready_n), 8'h1);
        check("mid_rst_force", 8'(force_ff), 8'h0);
        tick();
        tick(15);
        check("re_pre_ready", 8'(host_ready_n), 8'h1);
        tick();
        check("re_exp_ready", 8'(host_ready_n), 8'h0);
        check("re_exp_force", 8'(force_ff), 8'h1);
        check("re_exp_count", fault_count, 8'h1);
        end_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
